// File: rtl/grf_sboard_pkg.sv
// Shared types and widths for the GPR write scheduler / hazard scoreboard.
// Holds the grf write-port bundle and the buffered MD result record.
package grf_sboard_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_W;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef logic [REG_W-1:0]  reg_num_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic     RegWrite;
    reg_num_t Wreg;
    word_t    Wdata;
    word_t    pc;
  } grf_wr_t;

  typedef struct packed {
    reg_num_t wreg;
    word_t    data;
    word_t    pc;
  } md_entry_t;

  // $0 is hardwired, so it can never be the subject of a hazard.
  function automatic logic reg_pending(input logic [NUM_REGS-1:0] pend,
                                       input reg_num_t            r);
    return (r != REG_ZERO) && pend[r];
  endfunction

endpackage

// File: rtl/grf_wport_arb.sv
// Arbitrates the single grf write port between pipeline writeback and the
// one-entry MD buffer; writeback has priority until the buffer has starved.
module grf_wport_arb
  import grf_sboard_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      i_clk,
  input  logic      i_srst,
  input  logic      i_wb_en,
  input  reg_num_t  i_wb_reg,
  input  word_t     i_wb_data,
  input  word_t     i_wb_pc,
  input  logic      i_buf_full,
  input  md_entry_t i_buf,
  output logic      o_wb_hold,
  output logic      o_buf_drain,
  output grf_wr_t   o_grf
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;
  logic             w_wb_win;
  logic             w_buf_win;

  always_comb begin
    w_starved   = (r_starve_cnt == CNT_MAX);
    o_wb_hold   = ~i_srst & i_buf_full & i_wb_en & w_starved;
    w_wb_win    = ~i_srst & i_wb_en & ~o_wb_hold;
    w_buf_win   = ~i_srst & i_buf_full & ~w_wb_win;
    o_buf_drain = w_buf_win;

    o_grf = '0;
    if (w_wb_win) begin
      o_grf.RegWrite = 1'b1;
      o_grf.Wreg     = i_wb_reg;
      o_grf.Wdata    = i_wb_data;
      o_grf.pc       = i_wb_pc;
    end else if (w_buf_win) begin
      o_grf.RegWrite = 1'b1;
      o_grf.Wreg     = i_buf.wreg;
      o_grf.Wdata    = i_buf.data;
      o_grf.pc       = i_buf.pc;
    end
  end

  // Counts only cycles the buffered result lost the port to writeback.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_starve_cnt <= '0;
    end else if (!i_buf_full || w_buf_win) begin
      r_starve_cnt <= '0;
    end else if (w_wb_win && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/grf_sboard.sv
// GPR hazard scoreboard with a one-entry MD result buffer; stalls decode on
// RAW/WAW/MD-busy hazards and drives the grf write port via grf_wport_arb.
module grf_sboard
  import grf_sboard_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              sboard_clk,
  input  logic              sboard_reset,

  input  logic              sboard_id_valid,
  input  logic [REG_W-1:0]  sboard_id_rs,
  input  logic [REG_W-1:0]  sboard_id_rt,
  input  logic              sboard_id_use_rs,
  input  logic              sboard_id_use_rt,
  input  logic              sboard_id_wr,
  input  logic              sboard_id_md,
  input  logic [REG_W-1:0]  sboard_id_wreg,
  output logic              sboard_stall,
  output logic              sboard_issue,
  output logic              sboard_md_busy,

  input  logic              sboard_wb_en,
  input  logic [REG_W-1:0]  sboard_wb_reg,
  input  logic [DATA_W-1:0] sboard_wb_data,
  input  logic [DATA_W-1:0] sboard_wb_pc,
  output logic              sboard_wb_hold,

  input  logic              sboard_md_valid,
  input  logic [REG_W-1:0]  sboard_md_reg,
  input  logic [DATA_W-1:0] sboard_md_data,
  input  logic [DATA_W-1:0] sboard_md_pc,
  output logic              sboard_md_ready,

  output logic              sboard_grf_RegWrite,
  output logic [REG_W-1:0]  sboard_grf_Wreg,
  output logic [DATA_W-1:0] sboard_grf_Wdata,
  output logic [DATA_W-1:0] sboard_grf_pc
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_next;
  logic                r_md_busy;
  logic                r_buf_full;
  md_entry_t           r_buf;

  logic    w_rs_haz;
  logic    w_rt_haz;
  logic    w_waw_haz;
  logic    w_md_haz;
  logic    w_stall;
  logic    w_issue;
  logic    w_id_dst;
  logic    w_md_accept;
  logic    w_buf_drain;
  logic    w_wb_hold;
  grf_wr_t w_grf;

  // Hazards look only at registered state; a same-cycle clear is not bypassed.
  always_comb begin
    w_rs_haz  = sboard_id_use_rs & reg_pending(r_pending, sboard_id_rs);
    w_rt_haz  = sboard_id_use_rt & reg_pending(r_pending, sboard_id_rt);
    w_waw_haz = (sboard_id_wr | sboard_id_md) & reg_pending(r_pending, sboard_id_wreg);
    w_md_haz  = sboard_id_md & r_md_busy;
    w_id_dst  = (sboard_id_wr | sboard_id_md) & (sboard_id_wreg != REG_ZERO);
    w_stall   = sboard_reset |
                (sboard_id_valid & (w_rs_haz | w_rt_haz | w_waw_haz | w_md_haz));
    w_issue   = sboard_id_valid & ~w_stall;
  end

  assign w_md_accept = sboard_md_valid & sboard_md_ready;

  assign sboard_stall    = w_stall;
  assign sboard_issue    = w_issue;
  assign sboard_md_busy  = r_md_busy;
  assign sboard_md_ready = ~sboard_reset & ~r_buf_full;
  assign sboard_wb_hold  = w_wb_hold;

  assign sboard_grf_RegWrite = w_grf.RegWrite;
  assign sboard_grf_Wreg     = w_grf.Wreg;
  assign sboard_grf_Wdata    = w_grf.Wdata;
  assign sboard_grf_pc       = w_grf.pc;

  // WAW stalling keeps set and clear of one register in different cycles.
  assign w_pend_next[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pend
    logic w_set;
    logic w_clr;
    assign w_set = w_issue & w_id_dst & (sboard_id_wreg == REG_W'(gi));
    assign w_clr = w_grf.RegWrite & (w_grf.Wreg == REG_W'(gi));
    assign w_pend_next[gi] = w_set | (r_pending[gi] & ~w_clr);
  end

  always_ff @(posedge sboard_clk) begin
    if (sboard_reset) begin
      r_pending  <= '0;
      r_md_busy  <= 1'b0;
      r_buf_full <= 1'b0;
    end else begin
      r_pending <= w_pend_next;

      if (w_issue && sboard_id_md) begin
        r_md_busy <= 1'b1;
      end else if (w_buf_drain) begin
        r_md_busy <= 1'b0;
      end

      if (w_md_accept) begin
        r_buf_full <= 1'b1;
      end else if (w_buf_drain) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while r_buf_full is set, so it needs no reset.
  always_ff @(posedge sboard_clk) begin
    if (w_md_accept) begin
      r_buf.wreg <= sboard_md_reg;
      r_buf.data <= sboard_md_data;
      r_buf.pc   <= sboard_md_pc;
    end
  end

  grf_wport_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .i_clk       (sboard_clk),
    .i_srst      (sboard_reset),
    .i_wb_en     (sboard_wb_en),
    .i_wb_reg    (sboard_wb_reg),
    .i_wb_data   (sboard_wb_data),
    .i_wb_pc     (sboard_wb_pc),
    .i_buf_full  (r_buf_full),
    .i_buf       (r_buf),
    .o_wb_hold   (w_wb_hold),
    .o_buf_drain (w_buf_drain),
    .o_grf       (w_grf)
  );

endmodule

// File: tb/tb_grf_sboard.sv
// Bench for grf_sboard: directed vector table, hand-written starvation and
// reset sequences, then randomized traffic against a behavioural model.
module tb_grf_sboard;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, use_rs, use_rt, id_wr, id_md;
  logic [4:0]  id_rs, id_rt, id_wreg;
  logic        stall, issue, md_busy;
  logic        wb_en, wb_hold;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, wb_pc;
  logic        md_valid, md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data, md_pc;
  logic        g_we;
  logic [4:0]  g_reg;
  logic [31:0] g_data, g_pc;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grf_sboard #(.STARVE_MAX(STARVE_MAX)) dut (
    .sboard_clk          (clk),
    .sboard_reset        (rst),
    .sboard_id_valid     (id_valid),
    .sboard_id_rs        (id_rs),
    .sboard_id_rt        (id_rt),
    .sboard_id_use_rs    (use_rs),
    .sboard_id_use_rt    (use_rt),
    .sboard_id_wr        (id_wr),
    .sboard_id_md        (id_md),
    .sboard_id_wreg      (id_wreg),
    .sboard_stall        (stall),
    .sboard_issue        (issue),
    .sboard_md_busy      (md_busy),
    .sboard_wb_en        (wb_en),
    .sboard_wb_reg       (wb_reg),
    .sboard_wb_data      (wb_data),
    .sboard_wb_pc        (wb_pc),
    .sboard_wb_hold      (wb_hold),
    .sboard_md_valid     (md_valid),
    .sboard_md_reg       (md_reg),
    .sboard_md_data      (md_data),
    .sboard_md_pc        (md_pc),
    .sboard_md_ready     (md_ready),
    .sboard_grf_RegWrite (g_we),
    .sboard_grf_Wreg     (g_reg),
    .sboard_grf_Wdata    (g_data),
    .sboard_grf_pc       (g_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; use_rs = 1'b0; use_rt = 1'b0;
    id_wr = 1'b0; id_md = 1'b0; id_wreg = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0;
    md_valid = 1'b0; md_reg = '0; md_data = '0; md_pc = '0;
  endtask

  task automatic decode(input logic v, input int rs, input int urs, input int wr,
                        input int md, input int wreg);
    id_valid = v; id_rs = 5'(rs); use_rs = (urs != 0); id_rt = '0; use_rt = 1'b0;
    id_wr = (wr != 0); id_md = (md != 0); id_wreg = 5'(wreg);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int rst, v, rs, rt, urs, urt, wr, md, wreg, wbe, wbr, mdv, mdr;
    int stall, issue, ready, hold, rw, greg;
    bit [31:0] gdata;
    int busy;
  } vec_t;

  vec_t tbl[$];

  task automatic drive_vec(input vec_t t);
    rst = (t.rst != 0); id_valid = (t.v != 0); id_rs = 5'(t.rs); id_rt = 5'(t.rt);
    use_rs = (t.urs != 0); use_rt = (t.urt != 0); id_wr = (t.wr != 0); id_md = (t.md != 0);
    id_wreg = 5'(t.wreg);
    wb_en = (t.wbe != 0); wb_reg = 5'(t.wbr);
    wb_data = 32'hB000_0000 | 32'(t.wbr); wb_pc = 32'h0040_0000 + 32'(t.wbr) * 4;
    md_valid = (t.mdv != 0); md_reg = 5'(t.mdr); md_data = 32'h0000_1234; md_pc = 32'h0040_1000;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] p;
    int          waited;   // writeback wins seen while waiting
  } mbuf_t;

  bit         m_pend[32];
  bit         m_busy;
  mbuf_t      m_buf[$];
  logic [4:0] wbq[$];
  logic [4:0] mdq[$];
  bit         wb_keep, md_keep;

  initial begin
    vec_t  t;
    mbuf_t mb;
    bit    e_stall, e_issue, e_ready, e_hold, wb_won, buf_won, e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data, e_pc;
    int    kind;

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //            rst v rs rt urs urt wr md wreg wbe wbr mdv mdr  stl iss rdy hld rw greg gdata          busy
    tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 3,  1, 8,   1, 0, 0, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 1, 2, 1, 1, 1, 0, 5,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 5, 0, 1, 0, 1, 0, 6,  0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 5, 0, 1, 0, 1, 0, 6,  1, 5,  0, 0,   1, 0, 1, 0, 1, 5, 32'hB000_0005,  0});
    tbl.push_back('{0, 1, 5, 0, 1, 0, 1, 0, 6,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 1, 0, 0,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 1, 0, 0,  1, 6,  0, 0,   0, 1, 1, 0, 1, 6, 32'hB000_0006,  0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 1, 0, 0,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 8,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3,  1, 8,   0, 0, 1, 0, 1, 3, 32'hB000_0003,  1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 1, 8, 32'h0000_1234,  1});
    tbl.push_back('{0, 1, 8, 0, 1, 0, 0, 0, 0,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 9,  0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 32'h0,          1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 9,  0, 0,  0, 0,   1, 0, 1, 0, 0, 0, 32'h0,          1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 9,  0, 0,  1, 9,   1, 0, 1, 0, 0, 0, 32'h0,          1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 9,  0, 0,  0, 0,   1, 0, 0, 0, 1, 9, 32'h0000_1234,  1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 1, 10, 0, 0,  0, 0,   0, 1, 1, 0, 0, 0, 32'h0,          0});

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(negedge clk);
      drive_vec(t);
      #1;
      $display("vec %0d: stall=%b issue=%b ready=%b hold=%b we=%b reg=%0d busy=%b",
               i, stall, issue, md_ready, wb_hold, g_we, g_reg, md_busy);
      chkb("vec_stall", stall, t.stall != 0);
      chkb("vec_issue", issue, t.issue != 0);
      chkb("vec_md_ready", md_ready, t.ready != 0);
      chkb("vec_wb_hold", wb_hold, t.hold != 0);
      chkb("vec_grf_we", g_we, t.rw != 0);
      chkb("vec_md_busy", md_busy, t.busy != 0);
      if (t.rw != 0) begin
        chk("vec_grf_reg", 32'(g_reg), 32'(t.greg));
        chk("vec_grf_data", g_data, t.gdata);
      end
    end

    // ---------------- starvation: buffer full, writeback every cycle ----------------
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); idle(); decode(1'b1, 0, 0, 0, 1, 8); #1;
    chkb("starve_md_issue", issue, 1'b1);
    @(negedge clk); idle();
    md_valid = 1'b1; md_reg = 5'd8; md_data = 32'hCAFE_0008; md_pc = 32'h0040_2000; #1;
    chkb("starve_md_accept", md_ready, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); idle();
      wb_en = 1'b1; wb_reg = (k <= 5) ? 5'(20 + k) : 5'd25;
      wb_data = 32'hB000_0000 | 32'(wb_reg); wb_pc = 32'h0040_0100;
      #1;
      $display("starve cycle %0d: hold=%b we=%b reg=%0d data=%h ready=%b", k, wb_hold, g_we, g_reg, g_data, md_ready);
      chkb("starve_hold", wb_hold, k == 5);
      chkb("starve_we", g_we, 1'b1);
      chk("starve_reg", 32'(g_reg), (k == 5) ? 32'd8 : 32'(wb_reg));
      chk("starve_data", g_data, (k == 5) ? 32'hCAFE_0008 : (32'hB000_0000 | 32'(wb_reg)));
      chkb("starve_ready", md_ready, k == 6);
      chkb("starve_busy", md_busy, k != 6);
    end

    // ---------------- reset with $7 pending and buffer full ----------------
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); idle(); decode(1'b1, 0, 0, 1, 0, 7); #1;
    chkb("rst_seq_issue_wr7", issue, 1'b1);
    @(negedge clk); idle(); decode(1'b1, 0, 0, 0, 1, 8); #1;
    chkb("rst_seq_issue_md8", issue, 1'b1);
    @(negedge clk); idle(); md_valid = 1'b1; md_reg = 5'd8; md_data = 32'h5555_0008; #1;
    chkb("rst_seq_accept", md_ready, 1'b1);
    @(negedge clk); idle(); rst = 1'b1; decode(1'b1, 0, 0, 0, 0, 0);
    wb_en = 1'b1; wb_reg = 5'd12; wb_data = 32'h1; #1;
    $display("reset cycle: stall=%b issue=%b we=%b ready=%b hold=%b", stall, issue, g_we, md_ready, wb_hold);
    chkb("rst_stall", stall, 1'b1);
    chkb("rst_issue", issue, 1'b0);
    chkb("rst_grf_we", g_we, 1'b0);
    chkb("rst_md_ready", md_ready, 1'b0);
    chkb("rst_wb_hold", wb_hold, 1'b0);
    @(negedge clk); idle(); decode(1'b1, 7, 1, 0, 0, 0); #1;
    chkb("post_rst_reader7_issue", issue, 1'b1);
    chkb("post_rst_grf_we", g_we, 1'b0);
    chkb("post_rst_busy", md_busy, 1'b0);
    chkb("post_rst_ready", md_ready, 1'b1);
    @(negedge clk); idle(); #1;
    chkb("post_rst_buf_discarded", g_we, 1'b0);

    // ---------------- randomized traffic vs. model ----------------
    wb_keep = 0; md_keep = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 249) == 0);
      if (!wb_keep) begin
        if (wbq.size() != 0 && $urandom_range(0, 2) != 0) begin
          wb_en = 1'b1; wb_reg = wbq[0];
        end else begin
          wb_en = 1'b0; wb_reg = 5'($urandom);
        end
        wb_data = $urandom; wb_pc = $urandom;
      end
      if (!md_keep) begin
        if (mdq.size() != 0 && $urandom_range(0, 2) == 0) begin
          md_valid = 1'b1; md_reg = mdq[0];
        end else begin
          md_valid = 1'b0; md_reg = 5'($urandom);
        end
        md_data = $urandom; md_pc = $urandom;
      end
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      kind = $urandom_range(0, 2);
      id_wr = (kind == 1); id_md = (kind == 2);
      id_wreg = 5'($urandom_range(0, 7));
      #1;

      e_stall = rst || (id_valid && (
                  (use_rs && id_rs != 0 && m_pend[id_rs]) ||
                  (use_rt && id_rt != 0 && m_pend[id_rt]) ||
                  ((id_wr || id_md) && id_wreg != 0 && m_pend[id_wreg]) ||
                  (id_md && m_busy)));
      e_issue = id_valid && !e_stall;
      e_ready = !rst && m_buf.size() == 0;
      e_hold  = !rst && m_buf.size() != 0 && wb_en && m_buf[0].waited == STARVE_MAX;
      wb_won  = !rst && wb_en && !e_hold;
      buf_won = !rst && !wb_won && m_buf.size() != 0;
      e_we    = wb_won || buf_won;
      e_reg = '0; e_data = '0; e_pc = '0;
      if (wb_won) begin
        e_reg = wb_reg; e_data = wb_data; e_pc = wb_pc;
      end else if (buf_won) begin
        e_reg = m_buf[0].r; e_data = m_buf[0].d; e_pc = m_buf[0].p;
      end

      $display("rand %0d: rst=%b stall=%b issue=%b ready=%b hold=%b we=%b reg=%0d busy=%b",
               i, rst, stall, issue, md_ready, wb_hold, g_we, g_reg, md_busy);
      chkb("rand_stall", stall, e_stall);
      chkb("rand_issue", issue, e_issue);
      chkb("rand_md_ready", md_ready, e_ready);
      chkb("rand_wb_hold", wb_hold, e_hold);
      chkb("rand_md_busy", md_busy, m_busy);
      chkb("rand_grf_we", g_we, e_we);
      if (e_we) begin
        chk("rand_grf_reg", 32'(g_reg), 32'(e_reg));
        chk("rand_grf_data", g_data, e_data);
        chk("rand_grf_pc", g_pc, e_pc);
      end

      @(posedge clk);
      if (rst) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        m_busy = 1'b0;
        m_buf.delete(); wbq.delete(); mdq.delete();
        wb_keep = 0; md_keep = 0;
      end else begin
        if (e_we && e_reg != 0) m_pend[e_reg] = 1'b0;
        if (buf_won) begin
          m_busy = 1'b0;
          void'(m_buf.pop_front());
        end else if (wb_won && m_buf.size() != 0) begin
          mb = m_buf[0]; mb.waited++; m_buf[0] = mb;
        end
        if (e_issue && (id_wr || id_md) && id_wreg != 0) m_pend[id_wreg] = 1'b1;
        if (e_issue && id_md) m_busy = 1'b1;
        if (md_valid && e_ready) begin
          mb.r = md_reg; mb.d = md_data; mb.p = md_pc; mb.waited = 0;
          m_buf.push_back(mb);
        end
        wb_keep = wb_en && e_hold;
        if (wb_won) void'(wbq.pop_front());
        md_keep = md_valid && !e_ready;
        if (md_valid && e_ready) void'(mdq.pop_front());
        if (e_issue && id_wr) wbq.push_back(id_wreg);
        if (e_issue && id_md) mdq.push_back(id_wreg);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
